// File: rtl/pc_next_gen_pkg.sv
// Shared definitions for the next-PC generation stage: state encoding and
// default reset/trap vectors and sequential increment.
package pc_next_gen_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        HOLD       = 2'd2,
        HOLD_REDIR = 2'd3
    } pcg_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int          INC_DEF          = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect selector: priority trap > jump > branch, with
// misaligned targets rerouted to the trap vector.
module pc_redirect_sel #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = '0
) (
    input  logic            trap,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] branch_target,
    output logic            req,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        raw_target = branch_target;
        if (trap)      raw_target = TRAP_VECTOR;
        else if (jump) raw_target = jump_target;

        req        = trap | jump | branch_taken;
        misaligned = req && (raw_target[1:0] != 2'b00);
        target     = misaligned ? TRAP_VECTOR : raw_target;
    end

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC generation: sequential increment, stall hold, prioritised redirects,
// a pending redirect held across a stall, and a saturating redirect counter.
module pc_next_gen
    import pc_next_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              INC          = INC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    output logic [XLEN-1:0] pc_next,
    output logic            redirect,
    output logic            misalign_err,
    output logic [31:0]     redirect_cnt
);

    pcg_state_t      state, state_d;
    logic [XLEN-1:0] pend_target;
    logic            pend_misalign;

    logic            live_req, live_mis;
    logic [XLEN-1:0] live_target;
    logic            pend_req, pend_mis_sel;
    logic [XLEN-1:0] pend_sel_target;
    logic            pend_load;

    pc_redirect_sel #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR)) u_live_sel (
        .trap          (trap),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .req           (live_req),
        .target        (live_target),
        .misaligned    (live_mis)
    );

    // The pending target was already resolved when latched, so it passes
    // through unchanged; its stored misalign flag is merged below.
    pc_redirect_sel #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR)) u_pend_sel (
        .trap          (1'b0),
        .jump          (state == HOLD_REDIR),
        .branch_taken  (1'b0),
        .jump_target   (pend_target),
        .branch_target ('0),
        .req           (pend_req),
        .target        (pend_sel_target),
        .misaligned    (pend_mis_sel)
    );

    always_comb begin
        pc_next      = pc_cur;
        redirect     = 1'b0;
        misalign_err = 1'b0;
        pend_load    = 1'b0;
        state_d      = state;

        if (rst) begin
            pc_next = RESET_VECTOR;
        end else begin
            case (state)
                BOOT: begin
                    pc_next = RESET_VECTOR;
                    if (!stall) state_d = RUN;
                end
                default: begin
                    if (stall) begin
                        // Newest request overwrites any older pending one.
                        if (live_req) begin
                            pend_load = 1'b1;
                            state_d   = HOLD_REDIR;
                        end else if (state == RUN) begin
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = RUN;
                        if (live_req) begin
                            pc_next      = live_target;
                            redirect     = 1'b1;
                            misalign_err = live_mis;
                        end else if (pend_req) begin
                            pc_next      = pend_sel_target;
                            redirect     = 1'b1;
                            misalign_err = pend_misalign | pend_mis_sel;
                        end else begin
                            pc_next = pc_cur + XLEN'(INC);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= BOOT;
            pend_target   <= '0;
            pend_misalign <= 1'b0;
            redirect_cnt  <= '0;
        end else begin
            state <= state_d;
            if (pend_load) begin
                pend_target   <= live_target;
                pend_misalign <= live_mis;
            end
            if (redirect && (redirect_cnt != 32'hFFFF_FFFF))
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Self-checking bench for pc_next_gen: directed scenarios followed by random
// stimulus, compared each cycle against a behavioural model of the stage.
module tb_pc_next_gen;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam logic [31:0] INC = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        stall, branch_taken, jump, trap;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_next;
    logic        redirect, misalign_err;
    logic [31:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: "booting" and "a redirect is waiting" are all the
    // history the stage needs; HOLD and RUN are indistinguishable outside.
    bit          m_boot = 1'b1;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_tgt = '0;
    bit          m_pend_mis = 1'b0;
    logic [31:0] m_cnt = '0;

    logic [31:0] exp_pc;
    bit          exp_red, exp_mis;

    always #5 clk = ~clk;

    pc_next_gen dut (
        .clk           (clk),
        .rst           (rst),
        .pc_cur        (pc_cur),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .pc_next       (pc_next),
        .redirect      (redirect),
        .misalign_err  (misalign_err),
        .redirect_cnt  (redirect_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model at the
    // falling edge, advance the model at the rising edge, then let the
    // bench's PC register capture pc_next.
    task automatic step(input bit r, input bit s, input bit t, input bit j, input bit b,
                        input logic [31:0] jt, input logic [31:0] bt);
        logic [31:0] tgt, captured;
        bit          req, mis;
        rst = r; stall = s; trap = t; jump = j; branch_taken = b;
        jump_target = jt; branch_target = bt;

        req = t || j || b;
        tgt = t ? TV : (j ? jt : bt);
        mis = req && (tgt % 4 != 0);
        if (mis) tgt = TV;

        exp_red = 1'b0;
        exp_mis = 1'b0;
        if (r || m_boot)  exp_pc = RV;
        else if (s)       exp_pc = pc_cur;
        else if (req)   begin exp_pc = tgt;        exp_red = 1'b1; exp_mis = mis;        end
        else if (m_pend) begin exp_pc = m_pend_tgt; exp_red = 1'b1; exp_mis = m_pend_mis; end
        else              exp_pc = pc_cur + INC;

        @(negedge clk);
        check("pc_next", pc_next, exp_pc);
        check("redirect", {31'd0, redirect}, {31'd0, exp_red});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
        check("redirect_cnt", redirect_cnt, m_cnt);
        captured = pc_next;

        @(posedge clk);
        if (r) begin
            m_boot = 1'b1; m_pend = 1'b0; m_cnt = '0;
        end else if (m_boot) begin
            if (!s) m_boot = 1'b0;
        end else if (s) begin
            if (req) begin m_pend = 1'b1; m_pend_tgt = tgt; m_pend_mis = mis; end
        end else begin
            if (exp_red && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_pend = 1'b0;
        end
        #1;
        pc_cur = captured;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 3) != 0) v = v & 32'hFFFF_FFFC;
        return v;
    endfunction

    initial begin
        rst = 1'b1; pc_cur = '0; stall = 1'b0;
        trap = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = '0; branch_target = '0;

        // Reset, BOOT and sequential fetch.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("seq_pc4", pc_cur, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0);
        check("seq_pc8", pc_cur, 32'h8);

        // Taken branch, then sequential from the target.
        pc_cur = 32'h20;
        step(0, 0, 0, 0, 1, 32'h0, 32'h80);
        check("branch_pc", pc_cur, 32'h80);
        step(0, 0, 0, 0, 0, 0, 0);
        check("after_branch_pc", pc_cur, 32'h84);
        check("branch_cnt", redirect_cnt, 32'd1);

        // Trap beats jump and branch in the same cycle.
        step(0, 0, 1, 1, 1, 32'h40, 32'h80);
        check("trap_pc", pc_cur, TV);

        // Redirects during a stall: the newest one wins on release.
        pc_cur = 32'h1000;
        step(0, 1, 0, 1, 0, 32'h200, 32'h0);
        step(0, 1, 0, 0, 1, 32'h0, 32'h300);
        step(0, 1, 0, 0, 0, 0, 0);
        check("stall_hold_pc", pc_cur, 32'h1000);
        step(0, 0, 0, 0, 0, 0, 0);
        check("pend_release_pc", pc_cur, 32'h300);
        check("pend_release_cnt", redirect_cnt, 32'd3);

        // Misaligned jump: trap vector plus a one-cycle error pulse.
        step(0, 0, 0, 1, 0, 32'h202, 32'h0);
        check("misalign_pc", pc_cur, TV);
        step(0, 0, 0, 0, 0, 0, 0);

        // Wrap of the sequential increment.
        pc_cur = 32'hFFFF_FFFC;
        step(0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc_cur, 32'h0);

        // Reset while a redirect is pending discards it.
        step(0, 1, 0, 1, 0, 32'h400, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("rst_cnt", redirect_cnt, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_pc", pc_cur, 32'h4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) pc_cur = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0,
                 rand_target(), rand_target());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_next_gen.md
Name: pc_next_gen

Overview:
- Next-PC generation stage directly upstream of the PC register.
- Each cycle it computes the value driven onto the PC register's PC_in from the current PC (fed back from PC_out), stall, branch/jump/trap redirects and reset.
- Holds a pending redirect that arrives during a stall until the stall releases.
- Flags misaligned redirect targets and counts taken redirects.

Parameters:
- XLEN, 32, datapath width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, target for traps and misaligned redirects.
- INC, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  XLEN  current PC, from the PC register output.
- stall  in  1  hold PC; the downstream stage is not accepting.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_target  in  XLEN  branch destination.
- jump  in  1  unconditional jump (jal/jalr) this cycle.
- jump_target  in  XLEN  jump destination.
- trap  in  1  exception/ecall request.
- pc_next  out  XLEN  value to the PC register input.
- redirect  out  1  pc_next is non-sequential this cycle (flush hint).
- misalign_err  out  1  one-cycle pulse: a selected target had bits[1:0] != 0.
- redirect_cnt  out  32  number of redirects applied since reset, saturating.

Behaviour:
- States: BOOT, RUN, HOLD, HOLD_REDIR. Registered state: state, pend_target[XLEN-1:0], pend_misalign, redirect_cnt.
- Reset: while rst=1, pc_next=RESET_VECTOR, redirect=0, misalign_err=0. State goes to BOOT, pend cleared, redirect_cnt=0. rst overrides every other input, including mid-stall or with a pending redirect.
- BOOT: pc_next=RESET_VECTOR for one cycle so the PC register captures it, then go to RUN. stall in BOOT keeps state BOOT.
- Request selection is combinational, priority trap > jump > branch_taken.
  - Selected target: trap uses TRAP_VECTOR; jump uses jump_target; branch uses branch_target.
  - If the selected target has bits[1:0] != 0, the target becomes TRAP_VECTOR and misaligned=1.
- RUN, stall=0:
  - With a request: pc_next=target, redirect=1, misalign_err=misaligned, and redirect_cnt increments.
  - Without a request: pc_next=pc_cur+INC. Wraps modulo 2^XLEN, so 32'hFFFF_FFFC becomes 0.
- RUN, stall=1:
  - pc_next=pc_cur and redirect=0.
  - With a request: latch the target and misaligned flag into pend, then go to HOLD_REDIR.
  - Otherwise go to HOLD.
- HOLD: pc_next=pc_cur.
  - A request with stall=1: latch it, go to HOLD_REDIR.
  - stall=0: behave exactly as RUN with stall=0 this cycle, then go to RUN.
- HOLD_REDIR: pc_next=pc_cur while stall=1.
  - A new request overwrites pend. The newest redirect wins; trap priority applies only within a single cycle.
  - stall=0 with no new request: pc_next=pend_target, redirect=1, misalign_err=pend_misalign, counter increments, go to RUN.
  - stall=0 with a new request the same cycle: the new request wins over pend.
- Counter rules:
  - redirect_cnt saturates at 32'hFFFF_FFFF.
  - It increments exactly once per applied redirect, never on latching into pend.
- Latency: pc_next is combinational from inputs and state within the same cycle. The PC register adds one cycle, so a redirect asserted in cycle N appears on PC_out at cycle N+1.
- misalign_err is combinational and asserted only in the cycle the redirect is applied.

Decomposition:
- Shared package holds:
  - State encoding pcg_state_t (BOOT=2'd0, RUN=2'd1, HOLD=2'd2, HOLD_REDIR=2'd3).
  - RESET_VECTOR and TRAP_VECTOR defaults.
  - INC constant.
- One sub-module is natural: pc_redirect_sel, the combinational priority and misalignment selector. It returns req, target and misaligned, and is reused for both live and pend paths.

Test Plan:
- rst=1 for 2 cycles then release, no requests → pc_next=0x0 during reset and the BOOT cycle; then PC_out sequence 0x0, 0x4, 0x8; redirect_cnt=0.
- pc_cur=0x20, branch_taken=1, branch_target=0x80, stall=0 → pc_next=0x80, redirect=1, redirect_cnt=1; next cycle pc_next=0x84.
- Same cycle trap=1, jump=1 (0x40), branch_taken=1 (0x80) → pc_next=0x100, count +1.
- stall=1 for 3 cycles; jump_target=0x200 in cycle 1, then branch_target=0x300 in cycle 2; stall=0 in cycle 4 → pc_next held at pc_cur for 3 cycles, then 0x300 with redirect=1, count +1 only.
- jump=1, jump_target=0x202 → pc_next=0x100, misalign_err=1 for exactly one cycle.
- pc_cur=0xFFFF_FFFC, no request → pc_next=0x0. Separately, assert rst while in HOLD_REDIR → pend discarded, pc_next=RESET_VECTOR, redirect_cnt=0.
